md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_issue_ctrl.sv | 85 ++++++++
 tb/tb_md_issue_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue controller:
// opcode encodings, FSM state type and the default watchdog limit.
package md_pkg;

  localparam logic [2:0] OP_NE    = 3'b000;
  localparam logic [2:0] OP_MTHI  = 3'b001;
  localparam logic [2:0] OP_MTLO  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } md_state_e;

  // Operations that occupy the unit and therefore need a Start pulse.
  function automatic logic is_unit_op(input logic [2:0] op);
    return (op >= OP_MULTU) && (op <= OP_DIV);
  endfunction

  // Any opcode that touches HI/LO (111 is an unused encoding, treated as NE).
  function automatic logic is_hilo_op(input logic [2:0] op);
    return (op != OP_NE) && (op != 3'b111);
  endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Issue/stall control between the E stage and the multiply/divide unit,
// with a Busy watchdog that abandons an operation after TIMEOUT cycles.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] md_op_E,
  input  logic       hilo_rd_E,
  input  logic       ExcReq_E,
  input  logic       EI_HILO_ctr,
  input  logic       Busy,
  output logic       Start,
  output logic [2:0] Mul_Div_ctr,
  output logic       Stall,
  output logic       md_timeout
);

  localparam logic [4:0] TO_CNT = 5'(TIMEOUT);

  md_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       md_timeout_q, md_timeout_d;
  logic       mask_q, mask_d;

  logic busy_eff, to_hit, blocked, dep, kill, issue_ok, start_c;

  // After a timeout the stale Busy of the abandoned op is ignored until it drops.
  assign busy_eff = Busy & ~mask_q;
  assign to_hit   = (state_q == ST_WAIT) & busy_eff & (cnt_q == TO_CNT);
  assign blocked  = (state_q == ST_LAUNCH) | ((state_q == ST_WAIT) & busy_eff & ~to_hit);
  assign dep      = is_hilo_op(md_op_E) | hilo_rd_E;
  assign kill     = ExcReq_E | EI_HILO_ctr;
  assign issue_ok = ~reset & ~blocked & ~kill;
  assign start_c  = issue_ok & ~to_hit & is_unit_op(md_op_E);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      md_timeout_q <= 1'b0;
      mask_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_timeout_q <= md_timeout_d;
      mask_q       <= mask_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_timeout_d = md_timeout_q | to_hit;
    mask_d       = mask_q;
    unique case (state_q)
      ST_IDLE:   state_d = start_c ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (to_hit)        state_d = ST_IDLE;
        else if (busy_eff) state_d = ST_WAIT;
        else               state_d = start_c ? ST_LAUNCH : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (start_c)
      cnt_d = 5'd0;
    else if (((state_q == ST_LAUNCH) || (state_q == ST_WAIT)) && (cnt_q != 5'd31))
      cnt_d = cnt_q + 5'd1;
    if (to_hit)
      mask_d = 1'b1;
    else if ((state_q == ST_IDLE) && !Busy)
      mask_d = 1'b0;
  end

  always_comb begin
    Start       = start_c;
    Stall       = ~reset & dep & blocked;
    Mul_Div_ctr = (issue_ok && is_hilo_op(md_op_E)) ? md_op_E : OP_NE;
    md_timeout  = md_timeout_q | (~reset & to_hit);
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: issue, hazard stall, back-to-back issue,
// kill, watchdog timeout and reset-abandon scenarios.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] md_op_E;
  logic       hilo_rd_E;
  logic       ExcReq_E;
  logic       EI_HILO_ctr;
  logic       Busy;
  logic       Start;
  logic [2:0] Mul_Div_ctr;
  logic       Stall;
  logic       md_timeout;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  md_issue_ctrl #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .md_op_E     (md_op_E),
    .hilo_rd_E   (hilo_rd_E),
    .ExcReq_E    (ExcReq_E),
    .EI_HILO_ctr (EI_HILO_ctr),
    .Busy        (Busy),
    .Start       (Start),
    .Mul_Div_ctr (Mul_Div_ctr),
    .Stall       (Stall),
    .md_timeout  (md_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; md_op_E = OP_MULT; hilo_rd_E = 1'b1; ExcReq_E = 1'b0;
    EI_HILO_ctr = 1'b0; Busy = 1'b0;
    tick(); settle();
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_ctr",   32'(Mul_Div_ctr), 32'(OP_NE));
    md_op_E = OP_NE; hilo_rd_E = 1'b0;
    tick(); reset = 1'b0; settle();
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_cnt",   32'(dut.cnt_q), 32'd0);
    chk("rst_to",    32'(md_timeout), 32'd0);

    // mult from IDLE, Busy high cycles 1-4
    md_op_E = OP_MULT; settle();
    chk("mult_start", 32'(Start), 32'd1);
    chk("mult_ctr",   32'(Mul_Div_ctr), 32'(OP_MULT));
    tick(); md_op_E = OP_NE; Busy = 1'b1; settle();
    chk("mult_c1_state", 32'(dut.state_q), 32'(ST_LAUNCH));
    chk("mult_c1_start", 32'(Start), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      tick(); settle();
      chk("mult_wait_state", 32'(dut.state_q), 32'(ST_WAIT));
    end
    tick(); Busy = 1'b0; settle();
    chk("mult_c5_stall", 32'(Stall), 32'd0);
    tick(); settle();
    chk("mult_idle_state", 32'(dut.state_q), 32'(ST_IDLE));

    // div, then mflo at cycle 2 while Busy high cycles 1-9
    md_op_E = OP_DIV; settle();
    chk("div_start", 32'(Start), 32'd1);
    chk("div_ctr",   32'(Mul_Div_ctr), 32'(OP_DIV));
    tick(); md_op_E = OP_NE; Busy = 1'b1; settle();
    chk("div_c1_stall", 32'(Stall), 32'd0);
    tick(); hilo_rd_E = 1'b1;
    for (int c = 2; c <= 9; c++) begin
      settle();
      chk("mflo_stall", 32'(Stall), 32'd1);
      chk("mflo_nostart", 32'(Start), 32'd0);
      tick();
    end
    Busy = 1'b0; settle();
    chk("mflo_c10_stall", 32'(Stall), 32'd0);
    tick(); hilo_rd_E = 1'b0; settle();
    chk("div_idle_state", 32'(dut.state_q), 32'(ST_IDLE));

    // multu then divu back-to-back, Busy falls at cycle 5
    md_op_E = OP_MULTU; settle();
    chk("multu_start", 32'(Start), 32'd1);
    chk("multu_ctr",   32'(Mul_Div_ctr), 32'(OP_MULTU));
    tick(); md_op_E = OP_DIVU; Busy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("b2b_stall", 32'(Stall), 32'd1);
      chk("b2b_nostart", 32'(Start), 32'd0);
      chk("b2b_ctr_ne", 32'(Mul_Div_ctr), 32'(OP_NE));
      tick();
    end
    Busy = 1'b0; settle();
    chk("b2b_c5_stall", 32'(Stall), 32'd0);
    chk("b2b_c5_start", 32'(Start), 32'd1);
    chk("b2b_c5_ctr",   32'(Mul_Div_ctr), 32'(OP_DIVU));
    tick(); md_op_E = OP_NE; settle();
    chk("b2b_c6_state", 32'(dut.state_q), 32'(ST_LAUNCH));
    chk("b2b_c6_cnt",   32'(dut.cnt_q), 32'd0);
    tick(); tick(); settle();
    chk("b2b_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // killed ops and plain pass-through
    md_op_E = OP_MULT; ExcReq_E = 1'b1; settle();
    chk("exc_start", 32'(Start), 32'd0);
    chk("exc_ctr",   32'(Mul_Div_ctr), 32'(OP_NE));
    tick(); ExcReq_E = 1'b0; md_op_E = OP_MTHI; EI_HILO_ctr = 1'b1; settle();
    chk("exc_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("ei_ctr",    32'(Mul_Div_ctr), 32'(OP_NE));
    chk("ei_start",  32'(Start), 32'd0);
    tick(); EI_HILO_ctr = 1'b0; settle();
    chk("ei_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("mthi_ctr", 32'(Mul_Div_ctr), 32'(OP_MTHI));
    chk("mthi_nostart", 32'(Start), 32'd0);
    md_op_E = 3'b111; settle();
    chk("op7_ctr",   32'(Mul_Div_ctr), 32'(OP_NE));
    chk("op7_start", 32'(Start), 32'd0);
    tick(); md_op_E = OP_NE; settle();
    chk("op_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // watchdog: Busy high 20 cycles after Start, mfhi waiting in E
    md_op_E = OP_MULT; settle();
    chk("to_start", 32'(Start), 32'd1);
    tick(); md_op_E = OP_NE; hilo_rd_E = 1'b1; Busy = 1'b1; settle();
    chk("to_c1_stall", 32'(Stall), 32'd1);
    for (int c = 2; c <= 15; c++) begin
      tick(); settle();
      chk("to_wait_stall", 32'(Stall), 32'd1);
      chk("to_wait_flag",  32'(md_timeout), 32'd0);
    end
    tick(); settle();
    chk("to_c16_cnt",   32'(dut.cnt_q), 32'd15);
    chk("to_c16_flag",  32'(md_timeout), 32'd1);
    chk("to_c16_stall", 32'(Stall), 32'd0);
    tick(); settle();
    chk("to_c17_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("to_c17_flag",  32'(md_timeout), 32'd1);
    chk("to_c17_stall", 32'(Stall), 32'd0);
    for (int c = 18; c <= 20; c++) tick();
    Busy = 1'b0; hilo_rd_E = 1'b0;
    tick(); tick(); settle();
    chk("to_sticky", 32'(md_timeout), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0; settle();
    chk("to_cleared", 32'(md_timeout), 32'd0);

    // reset while in WAIT with mtlo stalled
    md_op_E = OP_MULT; settle();
    chk("rw_start", 32'(Start), 32'd1);
    tick(); md_op_E = OP_NE; Busy = 1'b1;
    tick(); md_op_E = OP_MTLO; settle();
    chk("rw_state", 32'(dut.state_q), 32'(ST_WAIT));
    chk("rw_stall", 32'(Stall), 32'd1);
    chk("rw_ctr",   32'(Mul_Div_ctr), 32'(OP_NE));
    tick(); reset = 1'b1; settle();
    chk("rw_rst_stall", 32'(Stall), 32'd0);
    chk("rw_rst_ctr",   32'(Mul_Div_ctr), 32'(OP_NE));
    tick(); reset = 1'b0; Busy = 1'b0; settle();
    chk("rw_after_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rw_after_stall", 32'(Stall), 32'd0);
    chk("rw_after_ctr",   32'(Mul_Div_ctr), 32'(OP_MTLO));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
